// File: rtl/mem_burst_master.sv
// Burst master for a single-port memory with combinational read.
// Splits write/read bursts into per-word memory accesses with handshakes.
module mem_burst_master #(
    parameter int N = 32,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [M-1:0] req_addr,
    input  logic [3:0]   req_len,
    input  logic [N-1:0] wdata,
    input  logic         wdata_valid,
    output logic         wdata_ready,
    output logic [N-1:0] rdata,
    output logic         rdata_valid,
    output logic         rdata_last,
    input  logic         rdata_ready,
    output logic         done,
    output logic [M-1:0] mem_address,
    output logic         mem_wf,
    output logic [N-1:0] mem_w,
    input  logic [N-1:0] mem_v
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ
    } state_t;

    localparam logic [M-1:0] ADDR_ONE = {{(M-1){1'b0}}, 1'b1};

    state_t       r_state;
    state_t       w_state_nxt;
    logic [M-1:0] r_cur_addr;
    logic [M-1:0] w_addr_nxt;
    logic [3:0]   r_beats_left;
    logic [3:0]   w_beats_nxt;
    logic [N-1:0] r_rdata;
    logic         r_rdata_valid;
    logic         r_rdata_last;
    logic         r_done;
    logic         w_wr_beat;
    logic         w_fetch;
    logic         w_consume;
    logic         w_last_beat;

    assign w_last_beat = (r_beats_left == 4'd0);
    assign w_consume   = r_rdata_valid && rdata_ready;

    assign mem_address = r_cur_addr;
    assign mem_w       = wdata;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign rdata_last  = r_rdata_last;
    assign done        = r_done;

    // Next-state, counter updates and handshake outputs per state
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_cur_addr;
        w_beats_nxt = r_beats_left;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        mem_wf      = 1'b0;
        w_wr_beat   = 1'b0;
        w_fetch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_addr_nxt  = req_addr;
                    w_beats_nxt = req_len;
                    w_state_nxt = req_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                wdata_ready = 1'b1;
                mem_wf      = wdata_valid;
                if (wdata_valid) begin
                    w_wr_beat  = 1'b1;
                    w_addr_nxt = r_cur_addr + ADDR_ONE;
                    if (w_last_beat) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_beats_nxt = r_beats_left - 4'd1;
                    end
                end
            end
            S_READ: begin
                // Fetch only when the output slot is empty or being drained
                if (!r_rdata_valid || rdata_ready) begin
                    w_fetch    = 1'b1;
                    w_addr_nxt = r_cur_addr + ADDR_ONE;
                    if (w_last_beat) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_beats_nxt = r_beats_left - 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, address pointer and remaining-beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_beats_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_addr   <= w_addr_nxt;
            r_beats_left <= w_beats_nxt;
        end
    end

    // Read output slot: load on fetch, empty on consumption
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_rdata_last  <= 1'b0;
        end else if (w_fetch) begin
            r_rdata       <= mem_v;
            r_rdata_valid <= 1'b1;
            r_rdata_last  <= w_last_beat;
        end else if (w_consume) begin
            r_rdata_valid <= 1'b0;
            r_rdata_last  <= 1'b0;
        end
    end

    // Completion pulse after last write beat or last read beat taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (w_wr_beat && w_last_beat) ||
                      (w_consume && r_rdata_last);
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed testbench for mem_burst_master with a behavioural memory.
// Each scenario task drives stimulus and checks hand-computed values.
module tb_mem_burst_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] wdata;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        rdata_last;
    logic        rdata_ready;
    logic        done;
    logic [15:0] mem_address;
    logic        mem_wf;
    logic [31:0] mem_w;
    logic [31:0] mem_v;

    int vecs = 0;
    int errs = 0;

    logic [31:0] mem [0:65535];
    logic [15:0] wf_addr [$];

    logic [31:0] wr_pat [16];
    int          gap_bad;
    logic        wr_done;

    logic [31:0] rd_data [16];
    logic        rd_last [16];
    int          rd_n;
    int          rd_unstable;
    int          rd_first;
    int          rd_lastcyc;
    logic        rd_done;

    mem_burst_master #(.N(32), .M(16)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_len(req_len),
        .wdata(wdata),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .rdata(rdata),
        .rdata_valid(rdata_valid),
        .rdata_last(rdata_last),
        .rdata_ready(rdata_ready),
        .done(done),
        .mem_address(mem_address),
        .mem_wf(mem_wf),
        .mem_w(mem_w),
        .mem_v(mem_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_v = mem[mem_address];

    // Behavioural memory plus a log of every write address
    always @(posedge clk) begin
        if (mem_wf) begin
            mem[mem_address] <= mem_w;
            wf_addr.push_back(mem_address);
        end
    end

    task automatic write_burst(input logic [15:0] a, input logic [3:0] len,
                               input int gap);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_len   = len;
        gap_bad   = 0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                #1;
                if (mem_wf) gap_bad++;
                @(negedge clk);
            end
            wdata       = wr_pat[b];
            wdata_valid = 1'b1;
            @(negedge clk);
        end
        wdata_valid = 1'b0;
        wr_done     = done;
    endtask

    task automatic read_burst(input logic [15:0] a, input logic [3:0] len,
                              input logic [3:0] rpat);
        logic        hv;
        logic        pr;
        logic [31:0] hd;
        logic        hl;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = a;
        req_len     = len;
        rdata_ready = 1'b0;
        @(negedge clk);
        req_valid   = 1'b0;
        rd_n        = 0;
        rd_unstable = 0;
        rd_first    = -1;
        rd_lastcyc  = -1;
        hv = 1'b0;
        pr = 1'b1;
        hd = '0;
        hl = 1'b0;
        for (int c = 0; c < 200 && rd_n <= int'(len); c++) begin
            if (hv && !pr && (rdata !== hd || rdata_last !== hl))
                rd_unstable++;
            if (rdata_valid && rd_first < 0) rd_first = c;
            rdata_ready = rpat[c % 4];
            if (rdata_valid && rdata_ready) begin
                rd_data[rd_n] = rdata;
                rd_last[rd_n] = rdata_last;
                rd_n++;
                rd_lastcyc = c;
            end
            hv = rdata_valid;
            hd = rdata;
            hl = rdata_last;
            pr = rdata_ready;
            @(negedge clk);
        end
        rdata_ready = 1'b0;
        rd_done     = done;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        vecs++; if (req_ready !== 1'b1) begin errs++;
            $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        vecs++; if (wdata_ready !== 1'b0) begin errs++;
            $display("FAIL rst_wdata_ready got %b exp 0", wdata_ready); end
        vecs++; if (mem_wf !== 1'b0) begin errs++;
            $display("FAIL rst_mem_wf got %b exp 0", mem_wf); end
        vecs++; if (rdata_valid !== 1'b0) begin errs++;
            $display("FAIL rst_rdata_valid got %b exp 0", rdata_valid); end
        vecs++; if (rdata_last !== 1'b0) begin errs++;
            $display("FAIL rst_rdata_last got %b exp 0", rdata_last); end
        vecs++; if (done !== 1'b0) begin errs++;
            $display("FAIL rst_done got %b exp 0", done); end
        vecs++; if (rdata !== 32'h0) begin errs++;
            $display("FAIL rst_rdata got %h exp 0", rdata); end
        vecs++; if (mem_address !== 16'h0) begin errs++;
            $display("FAIL rst_addr got %h exp 0", mem_address); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n0;
        n0 = wf_addr.size();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0001;
        req_len   = 4'd0;
        @(negedge clk);
        req_valid   = 1'b0;
        wdata       = 32'hcafebabe;
        wdata_valid = 1'b1;
        #1;
        vecs++; if (mem_wf !== 1'b1 || mem_address !== 16'h0001) begin
            errs++;
            $display("FAIL single_wr_strobe got wf=%b a=%h exp wf=1 a=0001",
                     mem_wf, mem_address); end
        vecs++; if (mem_w !== 32'hcafebabe) begin errs++;
            $display("FAIL single_mem_w got %h exp cafebabe", mem_w); end
        @(negedge clk);
        wdata_valid = 1'b0;
        #1;
        vecs++; if (done !== 1'b1) begin errs++;
            $display("FAIL single_wr_done got %b exp 1", done); end
        vecs++; if (mem_wf !== 1'b0 || req_ready !== 1'b1) begin errs++;
            $display("FAIL single_idle got wf=%b rr=%b exp wf=0 rr=1",
                     mem_wf, req_ready); end
        vecs++; if (wf_addr.size() - n0 !== 1) begin errs++;
            $display("FAIL single_wr_count got %0d exp 1",
                     wf_addr.size() - n0); end
        @(negedge clk);
        vecs++; if (done !== 1'b0) begin errs++;
            $display("FAIL single_done_pulse got %b exp 0", done); end
        read_burst(16'h0001, 4'd0, 4'b1111);
        vecs++; if (rd_n !== 1) begin errs++;
            $display("FAIL single_rd_count got %0d exp 1", rd_n); end
        vecs++; if (rd_data[0] !== 32'hcafebabe || rd_last[0] !== 1'b1) begin
            errs++;
            $display("FAIL single_rd_data got %h/%b exp cafebabe/1",
                     rd_data[0], rd_last[0]); end
        vecs++; if (rd_first !== 1) begin errs++;
            $display("FAIL single_rd_latency got %0d exp 1", rd_first); end
        vecs++; if (rd_done !== 1'b1) begin errs++;
            $display("FAIL single_rd_done got %b exp 1", rd_done); end
    endtask

    task automatic test_wrap();
        int n0;
        n0 = wf_addr.size();
        wr_pat[0] = 32'hdeadbeef;
        wr_pat[1] = 32'h12345678;
        write_burst(16'hffff, 4'd1, 0);
        vecs++; if (wf_addr.size() - n0 !== 2) begin errs++;
            $display("FAIL wrap_wr_count got %0d exp 2",
                     wf_addr.size() - n0); end
        else begin
            vecs++;
            if (wf_addr[n0] !== 16'hffff || wf_addr[n0+1] !== 16'h0000) begin
                errs++;
                $display("FAIL wrap_wr_addr got %h,%h exp ffff,0000",
                         wf_addr[n0], wf_addr[n0+1]); end
        end
        vecs++; if (wr_done !== 1'b1) begin errs++;
            $display("FAIL wrap_wr_done got %b exp 1", wr_done); end
        read_burst(16'hffff, 4'd1, 4'b1111);
        vecs++; if (rd_n !== 2) begin errs++;
            $display("FAIL wrap_rd_count got %0d exp 2", rd_n); end
        vecs++; if (rd_data[0] !== 32'hdeadbeef || rd_last[0] !== 1'b0) begin
            errs++;
            $display("FAIL wrap_rd0 got %h/%b exp deadbeef/0",
                     rd_data[0], rd_last[0]); end
        vecs++; if (rd_data[1] !== 32'h12345678 || rd_last[1] !== 1'b1) begin
            errs++;
            $display("FAIL wrap_rd1 got %h/%b exp 12345678/1",
                     rd_data[1], rd_last[1]); end
        vecs++; if (rd_lastcyc !== 2) begin errs++;
            $display("FAIL wrap_rd_thru got %0d exp 2", rd_lastcyc); end
    endtask

    task automatic test_read_stall();
        int          n0;
        logic [31:0] exp_d;
        for (int i = 0; i < 4; i++) wr_pat[i] = 32'h11111111 * (i + 1);
        write_burst(16'h0010, 4'd3, 0);
        n0 = wf_addr.size();
        wdata_valid = 1'b1;
        read_burst(16'h0010, 4'd3, 4'b1001);
        wdata_valid = 1'b0;
        vecs++; if (rd_n !== 4) begin errs++;
            $display("FAIL stall_rd_count got %0d exp 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'h11111111 * (i + 1);
            vecs++;
            if (rd_data[i] !== exp_d || rd_last[i] !== (i == 3)) begin
                errs++;
                $display("FAIL stall_rd%0d got %h/%b exp %h/%b", i,
                         rd_data[i], rd_last[i], exp_d, (i == 3)); end
        end
        vecs++; if (rd_unstable !== 0) begin errs++;
            $display("FAIL stall_hold got %0d changes exp 0", rd_unstable); end
        vecs++; if (rd_done !== 1'b1) begin errs++;
            $display("FAIL stall_done got %b exp 1", rd_done); end
        vecs++; if (wf_addr.size() - n0 !== 0) begin errs++;
            $display("FAIL stall_stray_wr got %0d exp 0",
                     wf_addr.size() - n0); end
        #1;
        vecs++; if (rdata_valid !== 1'b0) begin errs++;
            $display("FAIL stall_empty got %b exp 0", rdata_valid); end
        @(negedge clk);
    endtask

    task automatic test_write_gaps();
        int n0;
        n0 = wf_addr.size();
        for (int i = 0; i < 3; i++) wr_pat[i] = 32'h5a5a0000 + i;
        write_burst(16'h0020, 4'd2, 2);
        vecs++; if (wf_addr.size() - n0 !== 3) begin errs++;
            $display("FAIL gap_wr_count got %0d exp 3",
                     wf_addr.size() - n0); end
        else begin
            for (int i = 0; i < 3; i++) begin
                vecs++; if (wf_addr[n0+i] !== 16'h0020 + 16'(i)) begin
                    errs++;
                    $display("FAIL gap_wr_addr%0d got %h exp %h", i,
                             wf_addr[n0+i], 16'h0020 + 16'(i)); end
            end
        end
        vecs++; if (gap_bad !== 0) begin errs++;
            $display("FAIL gap_wf_in_gap got %0d exp 0", gap_bad); end
        vecs++; if (wr_done !== 1'b1) begin errs++;
            $display("FAIL gap_done got %b exp 1", wr_done); end
        vecs++; if (mem[16'h0022] !== 32'h5a5a0002) begin errs++;
            $display("FAIL gap_mem got %h exp 5a5a0002", mem[16'h0022]); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int n0;
        for (int i = 0; i < 4; i++) wr_pat[i] = 32'haaaa0000 + i;
        write_burst(16'h0030, 4'd3, 0);
        @(negedge clk);
        n0 = wf_addr.size();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0030;
        req_len   = 4'd3;
        @(negedge clk);
        req_valid   = 1'b0;
        wdata       = 32'hbbbb0000;
        wdata_valid = 1'b1;
        @(negedge clk);
        wdata = 32'hbbbb0001;
        @(negedge clk);
        wdata = 32'hbbbb0002;
        rst   = 1'b1;
        #1;
        vecs++; if (mem_wf !== 1'b0) begin errs++;
            $display("FAIL abort_wf got %b exp 0", mem_wf); end
        vecs++; if (req_ready !== 1'b1 || wdata_ready !== 1'b0) begin
            errs++;
            $display("FAIL abort_state got rr=%b wr=%b exp rr=1 wr=0",
                     req_ready, wdata_ready); end
        @(negedge clk);
        wdata_valid = 1'b0;
        rst         = 1'b0;
        @(negedge clk);
        vecs++; if (done !== 1'b0) begin errs++;
            $display("FAIL abort_done got %b exp 0", done); end
        vecs++; if (wf_addr.size() - n0 !== 2) begin errs++;
            $display("FAIL abort_wr_count got %0d exp 2",
                     wf_addr.size() - n0); end
        read_burst(16'h0030, 4'd3, 4'b1111);
        vecs++; if (rd_n !== 4) begin errs++;
            $display("FAIL abort_rd_count got %0d exp 4", rd_n); end
        vecs++; if (rd_data[0] !== 32'hbbbb0000 ||
                    rd_data[1] !== 32'hbbbb0001) begin errs++;
            $display("FAIL abort_new got %h,%h exp bbbb0000,bbbb0001",
                     rd_data[0], rd_data[1]); end
        vecs++; if (rd_data[2] !== 32'haaaa0002 ||
                    rd_data[3] !== 32'haaaa0003) begin errs++;
            $display("FAIL abort_old got %h,%h exp aaaa0002,aaaa0003",
                     rd_data[2], rd_data[3]); end
        // pending read beat must be dropped by reset
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = 16'h0030;
        req_len     = 4'd0;
        rdata_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        vecs++; if (rdata_valid !== 1'b1 || rdata !== 32'hbbbb0000) begin
            errs++;
            $display("FAIL abort_rd_pend got %b/%h exp 1/bbbb0000",
                     rdata_valid, rdata); end
        rst = 1'b1;
        #1;
        vecs++; if (rdata_valid !== 1'b0 || rdata !== 32'h0 ||
                    rdata_last !== 1'b0) begin errs++;
            $display("FAIL abort_rd_drop got %b/%h/%b exp 0/0/0",
                     rdata_valid, rdata, rdata_last); end
        @(negedge clk);
        rst         = 1'b0;
        rdata_ready = 1'b1;
        @(negedge clk);
        vecs++; if (done !== 1'b0 || rdata_valid !== 1'b0) begin errs++;
            $display("FAIL abort_rd_after got d=%b v=%b exp 0/0",
                     done, rdata_valid); end
        rdata_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = wf_addr.size();
        req_valid   = 1'b1;
        req_we      = 1'b1;
        req_addr    = 16'h0040;
        req_len     = 4'd1;
        wdata_valid = 1'b0;
        @(negedge clk);
        req_we   = 1'b0;
        req_addr = 16'h0010;
        req_len  = 4'd0;
        #1;
        vecs++; if (req_ready !== 1'b0 || mem_address !== 16'h0040) begin
            errs++;
            $display("FAIL busy_w0 got rr=%b a=%h exp rr=0 a=0040",
                     req_ready, mem_address); end
        @(negedge clk);
        vecs++; if (req_ready !== 1'b0 || mem_address !== 16'h0040) begin
            errs++;
            $display("FAIL busy_w1 got rr=%b a=%h exp rr=0 a=0040",
                     req_ready, mem_address); end
        wdata       = 32'h77770000;
        wdata_valid = 1'b1;
        @(negedge clk);
        wdata = 32'h77770001;
        @(negedge clk);
        wdata_valid = 1'b0;
        rdata_ready = 1'b1;
        #1;
        vecs++; if (req_ready !== 1'b1 || done !== 1'b1) begin errs++;
            $display("FAIL busy_idle got rr=%b d=%b exp 1/1",
                     req_ready, done); end
        @(negedge clk);
        req_valid = 1'b0;
        vecs++; if (req_ready !== 1'b0 || mem_address !== 16'h0010) begin
            errs++;
            $display("FAIL busy_rd_take got rr=%b a=%h exp rr=0 a=0010",
                     req_ready, mem_address); end
        vecs++; if (wf_addr.size() - n0 !== 2 ||
                    mem[16'h0041] !== 32'h77770001) begin errs++;
            $display("FAIL busy_wr got n=%0d m=%h exp 2/77770001",
                     wf_addr.size() - n0, mem[16'h0041]); end
        @(negedge clk);
        vecs++; if (rdata_valid !== 1'b1 || rdata !== 32'h11111111 ||
                    rdata_last !== 1'b1) begin errs++;
            $display("FAIL busy_rd got %b/%h/%b exp 1/11111111/1",
                     rdata_valid, rdata, rdata_last); end
        @(negedge clk);
        rdata_ready = 1'b0;
        vecs++; if (done !== 1'b1 || rdata_valid !== 1'b0) begin errs++;
            $display("FAIL busy_rd_done got d=%b v=%b exp 1/0",
                     done, rdata_valid); end
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_len     = '0;
        wdata       = '0;
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        gap_bad     = 0;
        wr_done     = 1'b0;
        rd_done     = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_read_stall();
        test_write_gaps();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
